// File: rtl/fir_mon_pkg.sv
// Shared types and helpers for the FIR output error monitor.
// The saturating add works on 64-bit carriers so one function serves every accumulator width up to 63 bits.
package fir_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SKIP  = 2'd1,
        ST_ACCUM = 2'd2,
        ST_DONE  = 2'd3
    } mon_state_t;

    localparam int MON_W     = 16;
    localparam int MON_DEPTH = 32;
    localparam int MON_ACC_W = 24;

    // Adds a and b, clamping the result to 2^width-1.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned width);
        logic [64:0] s;
        logic [63:0] lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        if (s > {1'b0, lim})
            return lim;
        return s[63:0];
    endfunction

endpackage

// File: rtl/fir_mon_gold_ram.sv
// Golden-sample store: synchronous write, combinational read.
// It has no reset, so the loaded sequence survives resets and repeated runs.
module fir_mon_gold_ram #(
    parameter int W     = 16,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [W-1:0]             wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [W-1:0]             rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fir_error_monitor.sv
// Compares the FIR output stream against a preloaded golden sequence after a warm-up skip,
// accumulating sum/max of absolute error and mismatch count.
//
// state    | meaning
// ST_IDLE  | waiting for start after reset, metrics zero
// ST_SKIP  | discarding filter fill-latency samples
// ST_ACCUM | comparing samples against gold[idx]
// ST_DONE  | DEPTH samples compared, metrics held
module fir_error_monitor
    import fir_mon_pkg::*;
#(
    parameter int W     = MON_W,
    parameter int DEPTH = MON_DEPTH,
    parameter int SKIP  = 4,
    parameter int ACC_W = MON_ACC_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     sample_valid,
    input  logic [W-1:0]             sample,
    input  logic                     gold_wr_en,
    input  logic [$clog2(DEPTH)-1:0] gold_wr_addr,
    input  logic [W-1:0]             gold_wr_data,
    output logic                     busy,
    output logic                     done,
    output logic [ACC_W-1:0]         sum_abs_err,
    output logic [W:0]               max_abs_err,
    output logic [$clog2(DEPTH):0]   mismatch_count,
    output logic [$clog2(DEPTH):0]   sample_count
);

    localparam int AW        = $clog2(DEPTH);
    localparam int CW        = AW + 1;
    localparam int SKW       = $clog2(SKIP + 2);
    localparam int SKIP_LAST = (SKIP > 0) ? SKIP - 1 : 0;

    mon_state_t        state;
    logic [SKW-1:0]    skip_cnt;
    logic [AW-1:0]     idx;
    logic [W-1:0]      gold;
    logic              wr_ok;
    logic signed [W:0] diff;
    logic [W:0]        abs_diff;
    logic [ACC_W-1:0]  sum_next;

    // Writes are only accepted outside a run, so the sequence under comparison never changes mid-run.
    assign wr_ok = (state == ST_IDLE) || (state == ST_DONE);

    fir_mon_gold_ram #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_gold_ram (
        .clk     (clk),
        .wr_en   (gold_wr_en && wr_ok),
        .wr_addr (gold_wr_addr),
        .wr_data (gold_wr_data),
        .rd_addr (idx),
        .rd_data (gold)
    );

    // Sign-extending both operands by one bit makes the difference exact; |diff| tops out at 2^W-1.
    always_comb begin
        diff     = $signed({sample[W-1], sample}) - $signed({gold[W-1], gold});
        abs_diff = diff[W] ? $unsigned(-diff) : $unsigned(diff);
        sum_next = ACC_W'(sat_add(64'(sum_abs_err), 64'(abs_diff), ACC_W));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            skip_cnt       <= '0;
            idx            <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            sum_abs_err    <= '0;
            max_abs_err    <= '0;
            mismatch_count <= '0;
            sample_count   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        skip_cnt       <= '0;
                        idx            <= '0;
                        sum_abs_err    <= '0;
                        max_abs_err    <= '0;
                        mismatch_count <= '0;
                        sample_count   <= '0;
                        done           <= 1'b0;
                        busy           <= 1'b1;
                        state          <= (SKIP == 0) ? ST_ACCUM : ST_SKIP;
                    end
                end
                ST_SKIP: begin
                    if (sample_valid) begin
                        if (skip_cnt == SKW'(SKIP_LAST))
                            state <= ST_ACCUM;
                        else
                            skip_cnt <= skip_cnt + 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (sample_valid) begin
                        sum_abs_err  <= sum_next;
                        idx          <= idx + 1'b1;
                        sample_count <= sample_count + 1'b1;
                        if (abs_diff > max_abs_err)
                            max_abs_err <= abs_diff;
                        if (diff != '0)
                            mismatch_count <= mismatch_count + 1'b1;
                        if (sample_count == CW'(DEPTH - 1)) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
